id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus load-use hazard detection for the 5-stage RV32I core.
- Captures decoded operands and control from ID and drives the EX-side signals, including ex_rs1, ex_rs2, ex_rd, ex_mem_write_ena and ex_reg_write_ena, that the forwarding unit and ALU consume.
- Inserts one bubble on a load-use dependency.
- Applies a write-through bypass for the same-cycle WB register write.
- Honours the memory-busy freeze and the branch flush.

Parameters:
XLEN, 32, datapath width
ALU_OP_W, 4, ALU opcode width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
id_valid  input  1  ID holds a real instruction
id_pc  input  XLEN  PC of ID instruction
id_rs1  input  5  source register 1 index
id_rs2  input  5  source register 2 index
id_rd  input  5  destination register index
id_use_rs1  input  1  instruction reads rs1
id_use_rs2  input  1  instruction reads rs2
id_imm  input  XLEN  decoded immediate
id_rs1_data  input  XLEN  register-file read port 1
id_rs2_data  input  XLEN  register-file read port 2
id_reg_write_ena  input  1  instruction writes rd
id_mem_read_ena  input  1  load
id_mem_write_ena  input  1  store
id_alu_op  input  ALU_OP_W  ALU operation
id_alu_src  input  1  1 = immediate as operand B
id_wb_sel  input  2  write-back source select
wb_reg_write_ena  input  1  WB writes the register file this cycle
wb_rd  input  5  WB destination
wb_wdata  input  XLEN  WB write data
flush  input  1  branch/jump resolved taken in EX; kill ID instruction
mem_busy  input  1  data memory not ready; freeze whole pipe
ex_valid  output  1  EX instruction valid
ex_pc  output  XLEN  registered id_pc
ex_rs1  output  5  registered id_rs1
ex_rs2  output  5  registered id_rs2
ex_rd  output  5  registered id_rd
ex_imm  output  XLEN  registered id_imm
ex_rs1_data  output  XLEN  registered operand 1 after WB bypass
ex_rs2_data  output  XLEN  registered operand 2 after WB bypass
ex_reg_write_ena  output  1  registered id_reg_write_ena
ex_mem_read_ena  output  1  registered id_mem_read_ena
ex_mem_write_ena  output  1  registered id_mem_write_ena
ex_alu_op  output  ALU_OP_W  registered id_alu_op
ex_alu_src  output  1  registered id_alu_src
ex_wb_sel  output  2  registered id_wb_sel
load_use_stall  output  1  hold PC and IF/ID this cycle (combinational)

Behaviour:
- Reset:
  - All ex_* registers are 0 on the rising edge of clk while rst_n=0; this is a NOP bubble.
  - load_use_stall is 0 while rst_n=0.
  - Reset asserted mid-stall discards the stalled instruction.
- Hazard detect (combinational), with hz = ex_valid & ex_mem_read_ena & (ex_rd!=0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)):
  - load_use_stall = hz & ~flush & ~mem_busy.
- Update priority at each clk edge with rst_n=1:
  1. mem_busy=1: hold all ex_* registers unchanged, ignoring flush and hz. Upstream also holds.
  2. flush=1: load bubble, i.e. all control bits and ex_valid = 0. Data fields are don't-care and load 0.
  3. hz=1: load bubble. The ID instruction stays in IF/ID and is re-presented next cycle.
  4. Otherwise: capture all id_* fields, with ex_valid = id_valid.
     - If id_valid=0, control enables are forced to 0.
- Bubble property: a bubble never writes regs or memory, so the forwarding unit sees ex_reg_write_ena=0 and ex_mem_write_ena=0.
- WB bypass:
  - Captured ex_rs1_data = wb_wdata if wb_reg_write_ena & wb_rd!=0 & wb_rd==id_rs1; else id_rs1_data.
  - The same rule applies to rs2.
  - x0 is never bypassed.
- Latency: exactly one cycle ID->EX when no stall, flush or busy.
- Load-use costs exactly one bubble. After the bubble, the load is in MEM and normal forwarding supplies the data.
- Back-to-back dependent loads: each dependent pair stalls once independently.

Optional Feature:
ID_EX_PERF_CNT_EN
- Defined: adds output ports perf_bubble_cnt and perf_flush_cnt (32-bit each).
  - perf_bubble_cnt increments on each edge where hz causes a bubble.
  - perf_flush_cnt increments on each edge where flush causes a bubble.
  - Neither counter increments while mem_busy=1.
  - Both are synchronously reset to 0 and wrap at 2^32-1 -> 0.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random id_* -> all ex_* = 0 and load_use_stall = 0; after release, first captured instruction appears 1 cycle later.
- Load-use: load x5 in EX (ex_mem_read_ena=1, ex_rd=5), ID add x6,x5,x7 with id_use_rs1=1 -> load_use_stall=1 and next ex_valid=0; cycle after, ex_rs1=5 and ex_valid=1.
- No false stall:
  - ex_rd=0 load -> load_use_stall=0.
  - id_use_rs2=0 with id_rs2==ex_rd -> load_use_stall=0.
- Flush vs hazard: flush=1 together with a load-use hazard -> load_use_stall=0 and a bubble is loaded.
- mem_busy held 3 cycles with flush=1 -> ex_* unchanged over all 3; the flush-and-busy cycle loads no bubble.
- WB bypass: id_rs1=3, id_rs1_data=0x11, wb_rd=3, wb_wdata=0xAB, wb_reg_write_ena=1 -> ex_rs1_data=0xAB. Repeat with wb_rd=0 -> ex_rs1_data=0x11.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and WB write-through bypass.
// Define ID_EX_PERF_CNT_EN to add the perf_bubble_cnt / perf_flush_cnt counters.
module id_ex_stage #(
   parameter int XLEN     = 32,
   parameter int ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   input  logic [XLEN-1:0]     id_pc,
   input  logic [4:0]          id_rs1,
   input  logic [4:0]          id_rs2,
   input  logic [4:0]          id_rd,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic [XLEN-1:0]     id_imm,
   input  logic [XLEN-1:0]     id_rs1_data,
   input  logic [XLEN-1:0]     id_rs2_data,
   input  logic                id_reg_write_ena,
   input  logic                id_mem_read_ena,
   input  logic                id_mem_write_ena,
   input  logic [ALU_OP_W-1:0] id_alu_op,
   input  logic                id_alu_src,
   input  logic [1:0]          id_wb_sel,
   input  logic                wb_reg_write_ena,
   input  logic [4:0]          wb_rd,
   input  logic [XLEN-1:0]     wb_wdata,
   input  logic                flush,
   input  logic                mem_busy,
   output logic                ex_valid,
   output logic [XLEN-1:0]     ex_pc,
   output logic [4:0]          ex_rs1,
   output logic [4:0]          ex_rs2,
   output logic [4:0]          ex_rd,
   output logic [XLEN-1:0]     ex_imm,
   output logic [XLEN-1:0]     ex_rs1_data,
   output logic [XLEN-1:0]     ex_rs2_data,
   output logic                ex_reg_write_ena,
   output logic                ex_mem_read_ena,
   output logic                ex_mem_write_ena,
   output logic [ALU_OP_W-1:0] ex_alu_op,
   output logic                ex_alu_src,
   output logic [1:0]          ex_wb_sel,
`ifdef ID_EX_PERF_CNT_EN
   output logic [31:0]         perf_bubble_cnt,
   output logic [31:0]         perf_flush_cnt,
`endif
   output logic                load_use_stall
);
   typedef struct packed {
      logic                valid;
      logic [XLEN-1:0]     pc;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [XLEN-1:0]     imm;
      logic [XLEN-1:0]     rs1_data;
      logic [XLEN-1:0]     rs2_data;
      logic                reg_write;
      logic                mem_read;
      logic                mem_write;
      logic [ALU_OP_W-1:0] alu_op;
      logic                alu_src;
      logic [1:0]          wb_sel;
   } ex_t;
   ex_t q, cap;
   logic hz;
   logic wb_hit1, wb_hit2;
   assign hz = q.valid & q.mem_read & (q.rd != 5'd0) & id_valid &
               ((id_use_rs1 & (id_rs1 == q.rd)) | (id_use_rs2 & (id_rs2 == q.rd)));
   assign load_use_stall = rst_n & hz & ~flush & ~mem_busy;
   // x0 never matches, so a WB "write" to x0 cannot leak into the operands
   assign wb_hit1 = wb_reg_write_ena & (wb_rd != 5'd0) & (wb_rd == id_rs1);
   assign wb_hit2 = wb_reg_write_ena & (wb_rd != 5'd0) & (wb_rd == id_rs2);
   always_comb begin
      cap           = '0;
      cap.valid     = id_valid;
      cap.pc        = id_pc;
      cap.rs1       = id_rs1;
      cap.rs2       = id_rs2;
      cap.rd        = id_rd;
      cap.imm       = id_imm;
      cap.rs1_data  = wb_hit1 ? wb_wdata : id_rs1_data;
      cap.rs2_data  = wb_hit2 ? wb_wdata : id_rs2_data;
      cap.reg_write = id_valid & id_reg_write_ena;
      cap.mem_read  = id_valid & id_mem_read_ena;
      cap.mem_write = id_valid & id_mem_write_ena;
      cap.alu_op    = id_alu_op;
      cap.alu_src   = id_alu_src;
      cap.wb_sel    = id_wb_sel;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) q <= '0;
      else if (!mem_busy) q <= (flush | hz) ? '0 : cap;
   end
`ifdef ID_EX_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_bubble_cnt <= '0;
         perf_flush_cnt  <= '0;
      end else if (!mem_busy) begin
         if (flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
         else if (hz) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end
   end
`endif
   assign ex_valid         = q.valid;
   assign ex_pc            = q.pc;
   assign ex_rs1           = q.rs1;
   assign ex_rs2           = q.rs2;
   assign ex_rd            = q.rd;
   assign ex_imm           = q.imm;
   assign ex_rs1_data      = q.rs1_data;
   assign ex_rs2_data      = q.rs2_data;
   assign ex_reg_write_ena = q.reg_write;
   assign ex_mem_read_ena  = q.mem_read;
   assign ex_mem_write_ena = q.mem_write;
   assign ex_alu_op        = q.alu_op;
   assign ex_alu_src       = q.alu_src;
   assign ex_wb_sel        = q.wb_sel;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
   logic        clk = 0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_use_rs1, id_use_rs2;
   logic [31:0] id_imm, id_rs1_data, id_rs2_data;
   logic        id_reg_write_ena, id_mem_read_ena, id_mem_write_ena;
   logic [3:0]  id_alu_op;
   logic        id_alu_src;
   logic [1:0]  id_wb_sel;
   logic        wb_reg_write_ena;
   logic [4:0]  wb_rd;
   logic [31:0] wb_wdata;
   logic        flush, mem_busy;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [31:0] ex_imm, ex_rs1_data, ex_rs2_data;
   logic        ex_reg_write_ena, ex_mem_read_ena, ex_mem_write_ena;
   logic [3:0]  ex_alu_op;
   logic        ex_alu_src;
   logic [1:0]  ex_wb_sel;
   logic        load_use_stall;
   int tests = 0;
   int fails = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_imm(id_imm),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_reg_write_ena(id_reg_write_ena), .id_mem_read_ena(id_mem_read_ena),
      .id_mem_write_ena(id_mem_write_ena), .id_alu_op(id_alu_op),
      .id_alu_src(id_alu_src), .id_wb_sel(id_wb_sel),
      .wb_reg_write_ena(wb_reg_write_ena), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
      .flush(flush), .mem_busy(mem_busy),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_reg_write_ena(ex_reg_write_ena),
      .ex_mem_read_ena(ex_mem_read_ena), .ex_mem_write_ena(ex_mem_write_ena),
      .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_wb_sel(ex_wb_sel),
      .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic ld, input logic wr);
      id_valid = v; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
      id_use_rs1 = u1; id_use_rs2 = u2; id_mem_read_ena = ld; id_reg_write_ena = wr;
      id_mem_write_ena = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; flush = 0; mem_busy = 0;
      wb_reg_write_ena = 0; wb_rd = 0; wb_wdata = 0;
      set_id(1, $urandom, 5'd7, 5'd1, 5'd2, 1, 1, 1, 1);
      id_imm = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_mem_write_ena = 1; id_alu_op = 4'hA; id_alu_src = 1; id_wb_sel = 2'd3;
      step(); step();
      tests++; if (ex_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", ex_valid); end
      tests++; if ({ex_pc, ex_rd, ex_imm, ex_rs1_data, ex_alu_op, ex_wb_sel} !== '0) begin fails++; $display("FAIL rst_data: pc=%h rd=%0d imm=%h", ex_pc, ex_rd, ex_imm); end
      tests++; if ({ex_reg_write_ena, ex_mem_read_ena, ex_mem_write_ena, ex_alu_src} !== 4'b0) begin fails++; $display("FAIL rst_ctrl: got %b exp 0000", {ex_reg_write_ena, ex_mem_read_ena, ex_mem_write_ena, ex_alu_src}); end
      tests++; if (load_use_stall !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b exp 0", load_use_stall); end
      rst_n = 1;
      set_id(1, 32'h40, 5'd8, 5'd1, 5'd2, 1, 1, 0, 1);
      step();
      tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h40 || ex_rd !== 5'd8 || ex_alu_op !== 4'hA) begin fails++; $display("FAIL rst_first: valid=%b pc=%h rd=%0d op=%h exp 1 40 8 a", ex_valid, ex_pc, ex_rd, ex_alu_op); end
   endtask

   task automatic test_load_use();
      set_id(1, 32'h100, 5'd5, 5'd1, 5'd0, 1, 0, 1, 1);
      step();
      tests++; if (ex_mem_read_ena !== 1'b1 || ex_rd !== 5'd5) begin fails++; $display("FAIL lu_load: rd=%0d ld=%b exp 5 1", ex_rd, ex_mem_read_ena); end
      set_id(1, 32'h104, 5'd6, 5'd5, 5'd7, 1, 1, 0, 1);
      #1;
      tests++; if (load_use_stall !== 1'b1) begin fails++; $display("FAIL lu_stall: got %b exp 1", load_use_stall); end
      step();
      tests++; if (ex_valid !== 1'b0 || ex_reg_write_ena !== 1'b0 || ex_mem_write_ena !== 1'b0) begin fails++; $display("FAIL lu_bubble: valid=%b wr=%b st=%b exp 000", ex_valid, ex_reg_write_ena, ex_mem_write_ena); end
      tests++; if (load_use_stall !== 1'b0) begin fails++; $display("FAIL lu_release: got %b exp 0", load_use_stall); end
      step();
      tests++; if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rd !== 5'd6 || ex_pc !== 32'h104) begin fails++; $display("FAIL lu_after: valid=%b rs1=%0d rd=%0d pc=%h exp 1 5 6 104", ex_valid, ex_rs1, ex_rd, ex_pc); end
   endtask

   task automatic test_back_to_back();
      set_id(1, 32'h200, 5'd10, 5'd1, 5'd0, 1, 0, 1, 1);
      step();
      set_id(1, 32'h204, 5'd11, 5'd10, 5'd0, 1, 0, 1, 1);
      #1;
      tests++; if (load_use_stall !== 1'b1) begin fails++; $display("FAIL b2b_stall1: got %b exp 1", load_use_stall); end
      step(); step();
      tests++; if (ex_valid !== 1'b1 || ex_rd !== 5'd11 || ex_mem_read_ena !== 1'b1) begin fails++; $display("FAIL b2b_load2: valid=%b rd=%0d ld=%b exp 1 11 1", ex_valid, ex_rd, ex_mem_read_ena); end
      set_id(1, 32'h208, 5'd12, 5'd3, 5'd11, 1, 1, 0, 1);
      #1;
      tests++; if (load_use_stall !== 1'b1) begin fails++; $display("FAIL b2b_stall2: got %b exp 1", load_use_stall); end
   endtask

   task automatic test_no_false_stall();
      set_id(1, 32'h300, 5'd0, 5'd1, 5'd0, 1, 0, 1, 0);
      step();
      set_id(1, 32'h304, 5'd4, 5'd0, 5'd0, 1, 1, 0, 1);
      #1;
      tests++; if (load_use_stall !== 1'b0) begin fails++; $display("FAIL nfs_x0: got %b exp 0", load_use_stall); end
      set_id(1, 32'h308, 5'd5, 5'd1, 5'd0, 1, 0, 1, 1);
      step();
      set_id(1, 32'h30C, 5'd6, 5'd2, 5'd5, 1, 0, 0, 1);
      #1;
      tests++; if (load_use_stall !== 1'b0) begin fails++; $display("FAIL nfs_use2: got %b exp 0", load_use_stall); end
      step();
      tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h30C) begin fails++; $display("FAIL nfs_capture: valid=%b pc=%h exp 1 30c", ex_valid, ex_pc); end
   endtask

   task automatic test_flush_hazard();
      set_id(1, 32'h400, 5'd5, 5'd1, 5'd0, 1, 0, 1, 1);
      step();
      set_id(1, 32'h404, 5'd6, 5'd5, 5'd0, 1, 0, 0, 1);
      flush = 1;
      #1;
      tests++; if (load_use_stall !== 1'b0) begin fails++; $display("FAIL fh_stall: got %b exp 0", load_use_stall); end
      step();
      flush = 0;
      tests++; if (ex_valid !== 1'b0 || ex_reg_write_ena !== 1'b0 || ex_mem_read_ena !== 1'b0) begin fails++; $display("FAIL fh_bubble: valid=%b wr=%b ld=%b exp 000", ex_valid, ex_reg_write_ena, ex_mem_read_ena); end
   endtask

   task automatic test_mem_busy_flush();
      set_id(1, 32'h500, 5'd9, 5'd1, 5'd0, 1, 0, 1, 1);
      step();
      set_id(1, 32'h504, 5'd13, 5'd9, 5'd0, 1, 0, 0, 1);
      mem_busy = 1; flush = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         tests++; if (load_use_stall !== 1'b0) begin fails++; $display("FAIL mb_stall%0d: got %b exp 0", i, load_use_stall); end
         step();
         tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h500 || ex_rd !== 5'd9 || ex_mem_read_ena !== 1'b1) begin fails++; $display("FAIL mb_hold%0d: valid=%b pc=%h rd=%0d ld=%b exp 1 500 9 1", i, ex_valid, ex_pc, ex_rd, ex_mem_read_ena); end
      end
      mem_busy = 0; flush = 0;
      #1;
      tests++; if (load_use_stall !== 1'b1) begin fails++; $display("FAIL mb_resume: got %b exp 1", load_use_stall); end
      step();
   endtask

   task automatic test_wb_bypass();
      set_id(1, 32'h600, 5'd14, 5'd3, 5'd4, 1, 1, 0, 1);
      id_rs1_data = 32'h11; id_rs2_data = 32'h22;
      wb_reg_write_ena = 1; wb_rd = 5'd3; wb_wdata = 32'hAB;
      step();
      tests++; if (ex_rs1_data !== 32'hAB || ex_rs2_data !== 32'h22) begin fails++; $display("FAIL byp_rs1: rs1=%h rs2=%h exp ab 22", ex_rs1_data, ex_rs2_data); end
      wb_rd = 5'd4;
      step();
      tests++; if (ex_rs1_data !== 32'h11 || ex_rs2_data !== 32'hAB) begin fails++; $display("FAIL byp_rs2: rs1=%h rs2=%h exp 11 ab", ex_rs1_data, ex_rs2_data); end
      wb_rd = 5'd0; id_rs1 = 5'd0;
      step();
      tests++; if (ex_rs1_data !== 32'h11) begin fails++; $display("FAIL byp_x0: rs1=%h exp 11", ex_rs1_data); end
      wb_rd = 5'd3; id_rs1 = 5'd3; wb_reg_write_ena = 0;
      step();
      tests++; if (ex_rs1_data !== 32'h11) begin fails++; $display("FAIL byp_noen: rs1=%h exp 11", ex_rs1_data); end
   endtask

   task automatic test_invalid_id();
      set_id(0, 32'h700, 5'd15, 5'd1, 5'd2, 0, 0, 1, 1);
      id_mem_write_ena = 1;
      step();
      tests++; if (ex_valid !== 1'b0 || ex_reg_write_ena !== 1'b0 || ex_mem_write_ena !== 1'b0 || ex_mem_read_ena !== 1'b0) begin fails++; $display("FAIL inv_ctrl: valid=%b wr=%b st=%b ld=%b exp 0000", ex_valid, ex_reg_write_ena, ex_mem_write_ena, ex_mem_read_ena); end
      tests++; if (ex_pc !== 32'h700) begin fails++; $display("FAIL inv_pc: got %h exp 700", ex_pc); end
   endtask

   task automatic test_reset_mid_stall();
      set_id(1, 32'h800, 5'd5, 5'd1, 5'd0, 1, 0, 1, 1);
      step();
      set_id(1, 32'h804, 5'd6, 5'd5, 5'd0, 1, 0, 0, 1);
      rst_n = 0;
      #1;
      tests++; if (load_use_stall !== 1'b0) begin fails++; $display("FAIL rms_stall: got %b exp 0", load_use_stall); end
      step();
      tests++; if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_mem_read_ena !== 1'b0) begin fails++; $display("FAIL rms_clear: valid=%b pc=%h ld=%b exp 0 0 0", ex_valid, ex_pc, ex_mem_read_ena); end
      rst_n = 1;
      step();
      tests++; if (ex_valid !== 1'b1 || ex_pc !== 32'h804) begin fails++; $display("FAIL rms_resume: valid=%b pc=%h exp 1 804", ex_valid, ex_pc); end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_back_to_back();
      test_no_false_stall();
      test_flush_hazard();
      test_mem_busy_flush();
      test_wb_bypass();
      test_invalid_id();
      test_reset_mid_stall();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
